// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package ifetch_pkg;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } fetch_state_e;

    localparam logic [31:0] NOP_INST         = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    function automatic logic [31:0] next_word(input logic [31:0] addr);
        return addr + 32'd4;
    endfunction

endpackage

// File: rtl/ifetch_pc.sv
// Program counter register: redirect beats sequential advance; targets are word-aligned.
module ifetch_pc
    import ifetch_pkg::*;
#(
    parameter int unsigned       XLEN     = 32,
    parameter logic [XLEN-1:0]   RESET_PC = DEFAULT_RESET_PC
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            advance,
    input  logic [XLEN-1:0] advance_base,
    output logic [XLEN-1:0] pc
);

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_d;
    logic            unused_redirect_lsb;

    // Low target bits are discarded, never trapped on.
    assign unused_redirect_lsb = ^redirect_pc[1:0];

    always_comb begin
        pc_d = pc_q;
        if (redirect_valid) begin
            pc_d = {redirect_pc[XLEN-1:2], 2'b00};
        end else if (advance) begin
            pc_d = next_word(advance_base);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc = pc_q;

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch: one outstanding memory request, one-entry output buffer to decode,
// and a redirect that discards any stale fetch.
module ifetch_unit
    import ifetch_pkg::*;
#(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            req_valid,
    input  logic            req_ready,
    output logic [XLEN-1:0] req_addr,
    input  logic            rsp_valid,
    input  logic [XLEN-1:0] rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] inst,
    output logic [XLEN-1:0] inst_pc
);

    fetch_state_e    state_q;
    logic            kill_q;
    logic [XLEN-1:0] fetch_pc_q;
    logic [XLEN-1:0] inst_q;
    logic [XLEN-1:0] inst_pc_q;
    logic [XLEN-1:0] pc;
    logic            advance;

    // A redirect cycle never issues a request nor offers an instruction.
    assign req_valid  = rst_n && (state_q == S_REQ) && !redirect_valid;
    assign req_addr   = pc;
    assign inst_valid = (state_q == S_HOLD) && !redirect_valid;
    assign inst       = inst_q;
    assign inst_pc    = inst_pc_q;

    assign advance = (state_q == S_WAIT) && rsp_valid && !kill_q && !redirect_valid;

    ifetch_pc #(
        .XLEN     (XLEN),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk            (clk),
        .rst_n          (rst_n),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .advance        (advance),
        .advance_base   (fetch_pc_q),
        .pc             (pc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_REQ;
            kill_q     <= 1'b0;
            fetch_pc_q <= RESET_PC;
            inst_q     <= NOP_INST;
            inst_pc_q  <= RESET_PC;
        end else begin
            unique case (state_q)
                S_REQ: begin
                    if (req_valid && req_ready) begin
                        fetch_pc_q <= pc;
                        state_q    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (rsp_valid) begin
                        if (advance) begin
                            inst_q    <= rsp_data;
                            inst_pc_q <= fetch_pc_q;
                            state_q   <= S_HOLD;
                        end else begin
                            // Stale word: either already killed or redirected this cycle.
                            kill_q  <= 1'b0;
                            state_q <= S_REQ;
                        end
                    end else if (redirect_valid) begin
                        kill_q <= 1'b1;
                    end
                end
                S_HOLD: begin
                    if (redirect_valid || inst_ready) begin
                        state_q <= S_REQ;
                    end
                end
                default: state_q <= S_REQ;
            endcase
        end
    end

endmodule

// File: tb/tb_ifetch_unit.sv
// Self-checking bench for ifetch_unit: directed scenarios plus a randomized run
// checked against a program-order fetch model.
module tb_ifetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;

    int n_cmp;
    int n_err;

    ifetch_unit #(
        .XLEN     (32),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_addr       (req_addr),
        .rsp_valid      (rsp_valid),
        .rsp_data       (rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Injective memory contents: odd multiplier is a bijection mod 2^32.
    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        return addr * 32'h9E37_79B1 + 32'h0000_0013;
    endfunction

    task automatic drive_idle();
        req_ready      = 1'b0;
        rsp_valid      = 1'b0;
        rsp_data       = 32'h0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        inst_ready     = 1'b0;
    endtask

    // Returns 1 time unit after a rising edge with inputs idle.
    task automatic next_cycle();
        @(posedge clk);
        #1;
        drive_idle();
    endtask

    // Leaves the bench in the first cycle after reset release.
    task automatic do_reset();
        rst_n = 1'b0;
        drive_idle();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive_idle();
        req_ready = 1'b1;
        @(posedge clk);
        #4;
        n_cmp++;
        if ({req_valid, inst_valid, inst, inst_pc} !== {1'b0, 1'b0, NOP, RESET_PC}) begin
            n_err++;
            $display("FAIL reset_outputs: got rv=%b iv=%b inst=%h pc=%h expected 0 0 %h %h",
                     req_valid, inst_valid, inst, inst_pc, NOP, RESET_PC);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #3;
        n_cmp++;
        if ({req_valid, req_addr, inst_valid} !== {1'b1, RESET_PC, 1'b0}) begin
            n_err++;
            $display("FAIL reset_first_req: got rv=%b addr=%h iv=%b expected 1 %h 0",
                     req_valid, req_addr, inst_valid, RESET_PC);
        end
    endtask

    task automatic test_basic();
        do_reset();
        req_ready = 1'b1;
        #3;
        n_cmp++;
        if ({req_valid, req_addr} !== {1'b1, 32'h0}) begin
            n_err++;
            $display("FAIL basic_req0: got %b %h expected 1 00000000", req_valid, req_addr);
        end
        next_cycle();
        rsp_valid = 1'b1;
        rsp_data  = 32'h0000_C237;
        #3;
        n_cmp++;
        if ({req_valid, inst_valid} !== 2'b00) begin
            n_err++;
            $display("FAIL basic_wait: got rv=%b iv=%b expected 0 0", req_valid, inst_valid);
        end
        next_cycle();
        inst_ready = 1'b1;
        #3;
        n_cmp++;
        if ({inst_valid, inst, inst_pc, req_valid} !== {1'b1, 32'h0000_C237, 32'h0, 1'b0}) begin
            n_err++;
            $display("FAIL basic_inst0: got %b %h %h rv=%b expected 1 0000c237 00000000 0",
                     inst_valid, inst, inst_pc, req_valid);
        end
        next_cycle();
        req_ready = 1'b1;
        #3;
        n_cmp++;
        if ({req_valid, req_addr} !== {1'b1, 32'h4}) begin
            n_err++;
            $display("FAIL basic_req1: got %b %h expected 1 00000004", req_valid, req_addr);
        end
        next_cycle();
        rsp_valid = 1'b1;
        rsp_data  = 32'h0000_F317;
        #3;
        next_cycle();
        inst_ready = 1'b1;
        #3;
        n_cmp++;
        if ({inst_valid, inst, inst_pc} !== {1'b1, 32'h0000_F317, 32'h4}) begin
            n_err++;
            $display("FAIL basic_inst1: got %b %h %h expected 1 0000f317 00000004",
                     inst_valid, inst, inst_pc);
        end
    endtask

    task automatic test_stall();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            if (i > 0) next_cycle();
            #3;
            n_cmp++;
            if ({req_valid, req_addr, inst_valid} !== {1'b1, 32'h0, 1'b0}) begin
                n_err++;
                $display("FAIL stall_hold[%0d]: got %b %h iv=%b expected 1 00000000 0",
                         i, req_valid, req_addr, inst_valid);
            end
        end
        next_cycle();
        req_ready = 1'b1;
        #3;
        next_cycle();
        #3;
        n_cmp++;
        if (req_valid !== 1'b0) begin
            n_err++;
            $display("FAIL stall_advance: got rv=%b expected 0", req_valid);
        end
    endtask

    task automatic test_redirect_wait();
        do_reset();
        req_ready = 1'b1;
        #3;
        next_cycle();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0102;
        #3;
        next_cycle();
        #3;
        next_cycle();
        #3;
        n_cmp++;
        if (req_valid !== 1'b0) begin
            n_err++;
            $display("FAIL redir_wait_idle: got rv=%b expected 0", req_valid);
        end
        next_cycle();
        rsp_valid = 1'b1;
        rsp_data  = 32'hFE20_89E3;
        #3;
        next_cycle();
        req_ready = 1'b1;
        #3;
        n_cmp++;
        if ({inst_valid, req_valid, req_addr} !== {1'b0, 1'b1, 32'h100}) begin
            n_err++;
            $display("FAIL redir_wait_req: got iv=%b rv=%b addr=%h expected 0 1 00000100",
                     inst_valid, req_valid, req_addr);
        end
        next_cycle();
        rsp_valid = 1'b1;
        rsp_data  = 32'h00A0_0093;
        #3;
        next_cycle();
        inst_ready = 1'b1;
        #3;
        n_cmp++;
        if ({inst_valid, inst, inst_pc} !== {1'b1, 32'h00A0_0093, 32'h100}) begin
            n_err++;
            $display("FAIL redir_wait_inst: got %b %h %h expected 1 00a00093 00000100",
                     inst_valid, inst, inst_pc);
        end
    endtask

    task automatic test_hold_redirect();
        do_reset();
        req_ready = 1'b1;
        #3;
        next_cycle();
        rsp_valid = 1'b1;
        rsp_data  = 32'h0010_8623;
        #3;
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            #3;
            n_cmp++;
            if ({inst_valid, inst, inst_pc} !== {1'b1, 32'h0010_8623, 32'h0}) begin
                n_err++;
                $display("FAIL hold_stable[%0d]: got %b %h %h expected 1 00108623 00000000",
                         i, inst_valid, inst, inst_pc);
            end
        end
        next_cycle();
        inst_ready     = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0200;
        #3;
        n_cmp++;
        if (inst_valid !== 1'b0) begin
            n_err++;
            $display("FAIL hold_redir_gate: got iv=%b expected 0", inst_valid);
        end
        next_cycle();
        req_ready = 1'b1;
        #3;
        n_cmp++;
        if ({inst_valid, req_valid, req_addr} !== {1'b0, 1'b1, 32'h200}) begin
            n_err++;
            $display("FAIL hold_redir_req: got iv=%b rv=%b addr=%h expected 0 1 00000200",
                     inst_valid, req_valid, req_addr);
        end
    endtask

    task automatic test_redirect_with_rsp();
        do_reset();
        req_ready = 1'b1;
        #3;
        next_cycle();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0300;
        rsp_valid      = 1'b1;
        rsp_data       = 32'hDEAD_BEEF;
        #3;
        next_cycle();
        req_ready = 1'b1;
        #3;
        n_cmp++;
        if ({inst_valid, req_valid, req_addr} !== {1'b0, 1'b1, 32'h300}) begin
            n_err++;
            $display("FAIL redir_rsp_req: got iv=%b rv=%b addr=%h expected 0 1 00000300",
                     inst_valid, req_valid, req_addr);
        end
        next_cycle();
        rsp_valid = 1'b1;
        rsp_data  = 32'h0040_0113;
        #3;
        next_cycle();
        inst_ready = 1'b1;
        #3;
        n_cmp++;
        if ({inst_valid, inst, inst_pc} !== {1'b1, 32'h0040_0113, 32'h300}) begin
            n_err++;
            $display("FAIL redir_rsp_inst: got %b %h %h expected 1 00400113 00000300",
                     inst_valid, inst, inst_pc);
        end
    endtask

    task automatic test_reset_mid_wait();
        do_reset();
        req_ready      = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0403;
        #3;
        n_cmp++;
        if (req_valid !== 1'b0) begin
            n_err++;
            $display("FAIL req_redir_gate: got rv=%b expected 0", req_valid);
        end
        next_cycle();
        req_ready = 1'b1;
        #3;
        n_cmp++;
        if ({req_valid, req_addr} !== {1'b1, 32'h400}) begin
            n_err++;
            $display("FAIL req_redir_addr: got %b %h expected 1 00000400", req_valid, req_addr);
        end
        next_cycle();
        #4;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({req_valid, inst_valid, inst, inst_pc} !== {1'b0, 1'b0, NOP, RESET_PC}) begin
            n_err++;
            $display("FAIL midwait_reset: got %b %b %h %h expected 0 0 %h %h",
                     req_valid, inst_valid, inst, inst_pc, NOP, RESET_PC);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive_idle();
        rsp_valid = 1'b1;
        rsp_data  = 32'hBADC_0DE0;
        #3;
        next_cycle();
        req_ready = 1'b1;
        #3;
        n_cmp++;
        if ({req_valid, req_addr, inst_valid} !== {1'b1, RESET_PC, 1'b0}) begin
            n_err++;
            $display("FAIL midwait_late_rsp: got %b %h iv=%b expected 1 %h 0",
                     req_valid, req_addr, inst_valid, RESET_PC);
        end
        next_cycle();
        rsp_valid = 1'b1;
        rsp_data  = 32'h0000_0513;
        #3;
        next_cycle();
        inst_ready = 1'b1;
        #3;
        n_cmp++;
        if ({inst_valid, inst, inst_pc} !== {1'b1, 32'h0000_0513, RESET_PC}) begin
            n_err++;
            $display("FAIL midwait_restart: got %b %h %h expected 1 00000513 %h",
                     inst_valid, inst, inst_pc, RESET_PC);
        end
    endtask

    // Model: instructions reach decode in program order from exp_pc; a redirect restarts
    // the order at the aligned target; memory answers each accepted request after 0-3 waits.
    task automatic test_random();
        logic [31:0] exp_pc;
        logic [31:0] pend_addr;
        logic [31:0] acc_addr;
        logic [31:0] prev_inst;
        logic [31:0] prev_pc;
        logic        pending;
        logic        accepted;
        logic        prev_hold;
        int          pend_cnt;
        int          n_xfer;

        exp_pc    = RESET_PC;
        pend_addr = 32'h0;
        acc_addr  = 32'h0;
        prev_inst = 32'h0;
        prev_pc   = 32'h0;
        pending   = 1'b0;
        accepted  = 1'b0;
        prev_hold = 1'b0;
        pend_cnt  = 0;
        n_xfer    = 0;
        do_reset();
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if (cyc > 0) next_cycle();
            if (accepted) begin
                pending   = 1'b1;
                pend_addr = acc_addr;
                pend_cnt  = int'($urandom_range(0, 3));
            end
            if (pending) begin
                if (pend_cnt == 0) begin
                    rsp_valid = 1'b1;
                    rsp_data  = mem_word(pend_addr);
                    pending   = 1'b0;
                end else begin
                    pend_cnt--;
                end
            end
            req_ready      = ($urandom_range(0, 3) != 0);
            inst_ready     = ($urandom_range(0, 2) != 0);
            redirect_valid = ($urandom_range(0, 11) == 0);
            redirect_pc    = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | $urandom_range(0, 15))
                                                         : $urandom;
            #3;
            if (redirect_valid) begin
                n_cmp++;
                if ({req_valid, inst_valid} !== 2'b00) begin
                    n_err++;
                    $display("FAIL rand_redir_gate @%0d: got rv=%b iv=%b expected 0 0",
                             cyc, req_valid, inst_valid);
                end
            end
            if (req_valid) begin
                n_cmp++;
                if ({pending, rsp_valid} !== 2'b00) begin
                    n_err++;
                    $display("FAIL rand_one_outstanding @%0d: got req while busy, expected idle",
                             cyc);
                end
            end
            if (req_valid && req_ready) begin
                n_cmp++;
                if (req_addr !== exp_pc) begin
                    n_err++;
                    $display("FAIL rand_req_addr @%0d: got %h expected %h", cyc, req_addr, exp_pc);
                end
            end
            if (prev_hold && !redirect_valid) begin
                n_cmp++;
                if ({inst_valid, inst, inst_pc} !== {1'b1, prev_inst, prev_pc}) begin
                    n_err++;
                    $display("FAIL rand_hold_stable @%0d: got %b %h %h expected 1 %h %h",
                             cyc, inst_valid, inst, inst_pc, prev_inst, prev_pc);
                end
            end
            if (inst_valid && inst_ready) begin
                n_cmp++;
                if ({inst, inst_pc} !== {mem_word(exp_pc), exp_pc}) begin
                    n_err++;
                    $display("FAIL rand_xfer @%0d: got %h %h expected %h %h",
                             cyc, inst, inst_pc, mem_word(exp_pc), exp_pc);
                end
                exp_pc = exp_pc + 32'd4;
                n_xfer++;
            end
            if (redirect_valid) exp_pc = {redirect_pc[31:2], 2'b00};
            accepted  = req_valid && req_ready;
            acc_addr  = req_addr;
            prev_hold = inst_valid && !inst_ready;
            prev_inst = inst;
            prev_pc   = inst_pc;
        end
        n_cmp++;
        if (n_xfer < 100) begin
            n_err++;
            $display("FAIL rand_progress: got %0d transfers expected at least 100", n_xfer);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        drive_idle();
        test_reset();
        test_basic();
        test_stall();
        test_redirect_wait();
        test_hold_redirect();
        test_redirect_with_rsp();
        test_reset_mid_wait();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
